// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          PC_STEP   = 4;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small synchronous FIFO holding {pc, instr} fetch entries
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    // A push into a full buffer is only taken when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: request FSM, pc_next mux and decode-side buffer
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int             XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int             BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t      state_q;
    logic [XLEN-1:0]   req_pc_q;
    logic [2*XLEN-1:0] head_data;
    logic              buf_full;
    logic              buf_empty;
    logic [CW-1:0]     buf_count;
    logic              pending;
    logic              room;
    logic              req_accept;
    logic              buf_push;
    logic              buf_pop;

    assign pending    = (state_q != S_REQ);
    assign room       = ~buf_full & ((buf_count + CW'(pending)) < CW'(BUF_DEPTH));
    assign imem_req_valid = reset & (state_q == S_REQ) & room & ~redirect_valid;
    assign imem_req_addr  = pc;
    assign req_accept     = imem_req_valid & imem_req_ready;

    // Only a response to a live request may enter the buffer; a redirect kills it.
    assign buf_push = (state_q == S_WAIT) & imem_rsp_valid & ~redirect_valid;
    assign buf_pop  = inst_valid & inst_ready;

    always_comb begin
        pc_next = pc;
        if (!reset) begin
            pc_next = RESET_PC;
        end else if (redirect_valid) begin
            pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (req_accept) begin
            pc_next = pc + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_REQ;
            req_pc_q <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_accept) begin
                        state_q  <= S_WAIT;
                        req_pc_q <= pc;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_q <= S_REQ;
                    end else if (redirect_valid) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (imem_rsp_valid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (2*XLEN)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data ({req_pc_q, imem_rsp_data}),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .head_data (head_data),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign inst_valid = ~buf_empty;
    assign inst_pc    = head_data[2*XLEN-1:XLEN];
    assign inst_data  = head_data[XLEN-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a transaction-level model
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [XLEN-1:0] pc = '0;
    logic [XLEN-1:0] pc_next;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [XLEN-1:0] imem_rsp_data = '0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    always #5 clk = ~clk;

    instr_fetch #(.XLEN(XLEN), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_next(pc_next),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the decode-visible instruction stream plus one outstanding-request flag.
    logic [63:0] q[$];
    logic [31:0] model_pc = '0;
    bit          m_out = 0, m_killed = 0;
    logic [31:0] m_pc = '0;
    bit          mem_busy = 0;
    int          mem_timer = 0;
    logic [31:0] mem_addr = '0;
    bit          drv_ready = 0, drv_iready = 0, drv_redir = 0, force_rsp = 0;
    logic [31:0] drv_rpc = '0;
    int          lat = 1;

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        exp_rv, acc, rsp, push_now;
        logic [31:0] exp_pcn;
        pc             = model_pc;
        imem_req_ready = drv_ready;
        inst_ready     = drv_iready;
        redirect_valid = drv_redir;
        redirect_pc    = drv_rpc;
        rsp            = (mem_busy && mem_timer == 1) || force_rsp;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? fdat(mem_busy ? mem_addr : 32'hDEAD_BEEF) : 32'($urandom);
        #1;
        exp_rv  = !m_out && (q.size() < DEPTH) && !drv_redir;
        acc     = exp_rv && drv_ready;
        exp_pcn = drv_redir ? {drv_rpc[31:2], 2'b00} : (acc ? model_pc + 32'd4 : model_pc);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", imem_req_addr, model_pc);
        chk("pc_next", pc_next, exp_pcn);
        chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("inst_pc", inst_pc, q[0][63:32]);
            chk("inst_data", inst_data, q[0][31:0]);
        end
        push_now = 0;
        if (m_out && rsp) begin
            push_now = !m_killed && !drv_redir;
            m_out    = 0;
            m_killed = 0;
        end else if (m_out && drv_redir) begin
            m_killed = 1;
        end
        if (mem_busy) begin
            if (mem_timer == 1) mem_busy = 0;
            else mem_timer--;
        end
        if (drv_redir) begin
            q.delete();
        end else begin
            if (drv_iready && q.size() != 0) void'(q.pop_front());
            if (push_now) q.push_back({m_pc, fdat(m_pc)});
        end
        if (acc) begin
            m_out = 1; m_pc = model_pc;
            mem_busy = 1; mem_addr = model_pc; mem_timer = lat;
        end
        model_pc = exp_pcn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        m_out = 0; m_killed = 0; mem_busy = 0; model_pc = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_pc_next", pc_next, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Fill with decode stalled, 1-cycle memory
        drv_ready = 1; lat = 1; drv_iready = 0;
        repeat (8) step();
        #1 chk("full_stall_pc_next", pc_next, 32'h8);
        @(negedge clk);

        // Drain, then memory not ready for 5 cycles
        drv_iready = 1; drv_ready = 0;
        repeat (3) step();
        repeat (5) step();

        // Redirect while waiting on a slow response
        drv_ready = 1; lat = 4;
        step();
        step();
        drv_redir = 1; drv_rpc = 32'h0000_0103;
        step();
        drv_redir = 0;
        repeat (6) step();

        // Redirect coincident with a response
        lat = 1;
        for (int i = 0; i < 10 && m_out; i++) step();
        step();
        drv_redir = 1; drv_rpc = 32'h0000_0200;
        step();
        drv_redir = 0;
        repeat (4) step();

        // Response with no request outstanding must be ignored
        drv_ready = 0;
        for (int i = 0; i < 10 && m_out; i++) step();
        force_rsp = 1;
        step();
        force_rsp = 0;
        step();

        // Wrap at the top of the address space
        drv_redir = 1; drv_rpc = 32'hFFFF_FFFE;
        step();
        drv_redir = 0; drv_ready = 1;
        repeat (4) step();

        // Reset while a request is in flight
        lat = 3; drv_iready = 0;
        for (int i = 0; i < 10 && !m_out; i++) step();
        step();
        reset = 1'b0;
        #1;
        chk("midrst_inst_valid", 32'(inst_valid), 32'h0);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("midrst_pc_next", pc_next, 32'h0);
        model_reset();
        @(posedge clk);
        #1 chk("midrst_state", 32'(dut.state_q), 32'(S_REQ));
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drv_ready  = ($urandom_range(3) != 0);
            drv_iready = ($urandom_range(9) < 6);
            drv_redir  = ($urandom_range(19) == 0);
            drv_rpc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                  : 32'($urandom);
            lat        = $urandom_range(1, 4);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
